challenge_sequencer: RTL and testbench

CHALLENGE_SEQUENCER -- requirements
Module: challenge_sequencer

---
 rtl/challenge_sequencer.sv | 129 ++++++++++++
 tb/tb_challenge_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/challenge_sequencer.sv
// Challenge sequencer: issues NUM_CHAL consecutive challenges (seed + k) to a PUF
// mapping block, captures each response and hands it to a consumer via valid/ready.
module challenge_sequencer #(
   parameter int unsigned IN_WIDTH  = 128,
   parameter int unsigned OUT_WIDTH = 16,
   parameter int unsigned NUM_CHAL  = 8,
   parameter int unsigned TIMEOUT   = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [IN_WIDTH-1:0]  seed,
   output logic                 map_trigger,
   output logic [IN_WIDTH-1:0]  map_challenge,
   input  logic                 map_done,
   input  logic [OUT_WIDTH-1:0] map_response,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [OUT_WIDTH-1:0] resp_data,
   output logic [7:0]           resp_index,
   output logic                 busy,
   output logic                 finished,
   output logic                 timeout_err
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned KW = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_HOLD,
      S_FINISH
   } state_t;

   state_t              state_q, state_d;
   logic [KW-1:0]       k_q, k_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [IN_WIDTH-1:0] seed_q, seed_d;
   logic                err_d;
   logic                capture;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state and datapath control
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      timer_d = timer_q;
      seed_d  = seed_q;
      err_d   = timeout_err;
      capture = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               seed_d  = seed;
               k_d     = '0;
               err_d   = 1'b0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            timer_d = timer_q + TW'(1);
            // A response arriving on the last allowed cycle still counts
            if (map_done) begin
               capture = 1'b1;
               state_d = S_HOLD;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_FINISH;
            end
         end
         S_HOLD: begin
            if (resp_ready) begin
               if (k_q == KW'(NUM_CHAL - 1)) begin
                  state_d = S_FINISH;
               end else begin
                  k_d     = k_q + KW'(1);
                  state_d = S_ISSUE;
               end
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath and registered outputs, decoded from the upcoming state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         k_q           <= '0;
         timer_q       <= '0;
         seed_q        <= '0;
         map_trigger   <= 1'b0;
         map_challenge <= '0;
         resp_valid    <= 1'b0;
         resp_data     <= '0;
         resp_index    <= '0;
         busy          <= 1'b0;
         finished      <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         k_q           <= k_d;
         timer_q       <= timer_d;
         seed_q        <= seed_d;
         map_trigger   <= (state_d == S_ISSUE);
         map_challenge <= (state_d == S_ISSUE || state_d == S_WAIT) ?
                          seed_d + IN_WIDTH'(k_d) : '0;
         resp_valid    <= (state_d == S_HOLD);
         busy          <= (state_d != S_IDLE);
         finished      <= (state_d == S_FINISH);
         timeout_err   <= err_d;
         if (capture) begin
            resp_data  <= map_response;
            resp_index <= k_q;
         end
      end
   end

endmodule

// File: tb/tb_challenge_sequencer.sv
// Directed bench for challenge_sequencer with a latency-programmable mapping-block model.
module tb_challenge_sequencer;

   localparam int unsigned IN_WIDTH  = 128;
   localparam int unsigned OUT_WIDTH = 16;
   localparam int unsigned NUM_CHAL  = 4;
   localparam int unsigned TIMEOUT   = 32;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 start = 1'b0;
   logic [IN_WIDTH-1:0]  seed = '0;
   logic                 map_trigger;
   logic [IN_WIDTH-1:0]  map_challenge;
   logic                 map_done;
   logic [OUT_WIDTH-1:0] map_response;
   logic                 resp_valid;
   logic                 resp_ready = 1'b0;
   logic [OUT_WIDTH-1:0] resp_data;
   logic [7:0]           resp_index;
   logic                 busy;
   logic                 finished;
   logic                 timeout_err;

   challenge_sequencer #(
      .IN_WIDTH (IN_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .NUM_CHAL (NUM_CHAL),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .seed         (seed),
      .map_trigger  (map_trigger),
      .map_challenge(map_challenge),
      .map_done     (map_done),
      .map_response (map_response),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_data    (resp_data),
      .resp_index   (resp_index),
      .busy         (busy),
      .finished     (finished),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Mapping-block model: responds lat cycles after the trigger, skips trigger drop_k
   int                   lat     = 16;
   int                   drop_k  = -1;
   int                   cnt     = 0;
   int                   trig_no = 0;
   logic [IN_WIDTH-1:0]  chal    = '0;
   logic                 model_done = 1'b0;
   logic [OUT_WIDTH-1:0] model_resp = '0;
   logic                 spur_done  = 1'b0;

   assign map_done     = model_done | spur_done;
   assign map_response = spur_done ? 16'hFFFF : model_resp;

   always @(negedge clk) begin
      model_done = 1'b0;
      if (!reset || !busy) begin
         cnt     = 0;
         trig_no = 0;
      end else begin
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               model_done = 1'b1;
               model_resp = chal[15:0] ^ 16'hA5A5;
               check("chal_stable", map_challenge, chal);
            end
         end
         if (map_trigger) begin
            if (trig_no != drop_k) begin
               cnt  = lat;
               chal = map_challenge;
            end
            trig_no++;
         end
      end
   end

   // Monitor
   int             cyc = 0;
   int             n_trig = 0;
   int             n_fin = 0;
   int             fin_cyc = 0;
   int             valid_cyc = -1;
   int             trig_cyc[$];
   logic [15:0]    got_data[$];
   logic [7:0]     got_idx[$];

   always @(negedge clk) begin
      cyc++;
      if (map_trigger) begin
         n_trig++;
         trig_cyc.push_back(cyc);
      end
      if (resp_valid && valid_cyc < 0) valid_cyc = cyc;
      if (resp_valid && resp_ready) begin
         got_data.push_back(resp_data);
         got_idx.push_back(resp_index);
      end
      if (finished) begin
         n_fin++;
         fin_cyc = cyc;
      end
   end

   task automatic do_start(input logic [IN_WIDTH-1:0] s);
      @(negedge clk);
      n_trig = 0; n_fin = 0; valid_cyc = -1;
      trig_cyc.delete(); got_data.delete(); got_idx.delete();
      seed  = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
      check("idle_wait", busy, 1'b0);
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 200 && !resp_valid; i++) @(negedge clk);
      check("valid_wait", resp_valid, 1'b1);
   endtask

   task automatic check_resps(input logic [IN_WIDTH-1:0] s, input int n);
      logic [IN_WIDTH-1:0] c;
      check("n_resp", got_data.size(), n);
      for (int i = 0; i < got_data.size() && i < n; i++) begin
         c = s + IN_WIDTH'(i);
         check("resp_data", got_data[i], c[15:0] ^ 16'hA5A5);
         check("resp_index", got_idx[i], i);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},     busy, 1'b0);
      check({tag, "_trigger"},  map_trigger, 1'b0);
      check({tag, "_chal"},     map_challenge, '0);
      check({tag, "_valid"},    resp_valid, 1'b0);
      check({tag, "_data"},     resp_data, '0);
      check({tag, "_index"},    resp_index, '0);
      check({tag, "_finished"}, finished, 1'b0);
      check({tag, "_err"},      timeout_err, 1'b0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Nominal run, consumer always ready
      lat = 16; drop_k = -1; resp_ready = 1'b1;
      do_start(128'h10);
      check("first_chal", map_challenge, 128'h10);
      check("first_trig", map_trigger, 1'b1);
      wait_idle();
      check_resps(128'h10, 4);
      check("a_n_fin", n_fin, 1);
      check("a_n_trig", n_trig, 4);
      check("a_err", timeout_err, 1'b0);
      check("a_latency", valid_cyc - trig_cyc[0], 17);
      check("a_idle_chal", map_challenge, '0);

      // Stalled consumer at k=1 with stray start and map_done during HOLD
      resp_ready = 1'b0;
      do_start(128'h10);
      for (int r = 0; r < 4; r++) begin
         wait_valid();
         if (resp_index == 8'd1) begin
            for (int s = 0; s < 5; s++) begin
               check("b_hold_valid", resp_valid, 1'b1);
               check("b_hold_data", resp_data, 16'hA5B4);
               check("b_hold_index", resp_index, 8'd1);
               check("b_hold_trig", map_trigger, 1'b0);
               start     = (s == 0);
               spur_done = (s == 0);
               @(negedge clk);
            end
         end
         resp_ready = 1'b1;
         @(negedge clk);
         resp_ready = 1'b0;
      end
      wait_idle();
      check_resps(128'h10, 4);
      check("b_n_trig", n_trig, 4);
      check("b_n_fin", n_fin, 1);
      check("b_err", timeout_err, 1'b0);

      // Mapping block never answers challenge 2
      resp_ready = 1'b1; drop_k = 2;
      do_start(128'h10);
      wait_idle();
      check_resps(128'h10, 2);
      check("c_err", timeout_err, 1'b1);
      check("c_n_fin", n_fin, 1);
      check("c_timeout_cycles", fin_cyc - trig_cyc[2], TIMEOUT + 1);

      // Response on exactly the last WAIT cycle; new start clears the sticky error
      drop_k = -1; lat = TIMEOUT;
      do_start(128'h10);
      check("d_err_cleared", timeout_err, 1'b0);
      wait_idle();
      check_resps(128'h10, 4);
      check("d_err", timeout_err, 1'b0);
      check("d_n_fin", n_fin, 1);

      // Asynchronous reset while waiting on challenge 2
      lat = 16;
      do_start(128'h10);
      for (int i = 0; i < 500 && n_trig < 3; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      check("e_busy_before", busy, 1'b1);
      check("e_chal_before", map_challenge, 128'h12);
      reset = 1'b0;
      #1;
      check_all_zero("e_async");
      repeat (3) @(negedge clk);
      check("e_no_fin", n_fin, 0);
      reset = 1'b1;
      @(negedge clk);
      do_start('0);
      check("e_restart_trig", map_trigger, 1'b1);
      check("e_restart_chal", map_challenge, '0);
      wait_idle();
      check_resps('0, 4);
      check("e_n_fin", n_fin, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
